// File: rtl/control_pkg.sv
// Shared encodings for the RV32I multicycle main control FSM and its ALU decoder.
package control_pkg;

  localparam int unsigned STATE_W   = 4;
  localparam int unsigned OPCODE_W  = 7;
  localparam int unsigned FUNCT3_W  = 3;
  localparam int unsigned SEL_W     = 2;
  localparam int unsigned ALUCTRL_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_LW     = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_SW     = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_IALU   = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;

  localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
  localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

  localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_A     = 2'b10;

  localparam logic [SEL_W-1:0] SRCB_WD   = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [ALUCTRL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUCTRL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUCTRL_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALUCTRL_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALUCTRL_W-1:0] ALU_SLT = 3'b101;

  // Per-state control word produced by the FSM output decode.
  typedef struct packed {
    logic             pc_update;
    logic             branch;
    logic             adr_src;
    logic             mem_write;
    logic             ir_write;
    logic             reg_write;
    logic [SEL_W-1:0] result_src;
    logic [SEL_W-1:0] alu_src_a;
    logic [SEL_W-1:0] alu_src_b;
    aluop_t           aluop;
  } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps aluop plus instruction fields to an ALU control code.
module alu_decoder
  import control_pkg::*;
(
  input  aluop_t               aluop_i,
  input  logic [FUNCT3_W-1:0]  funct3_i,
  input  logic                 op_b5_i,
  input  logic                 funct7_b5_i,
  output logic [ALUCTRL_W-1:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (aluop_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // Only R-type with funct7[5] set is sub; addi ignores instr[30].
          3'b000:  alu_control_o = (op_b5_i && funct7_b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore main control FSM for the RV32I multicycle datapath: sequences each
// instruction over 2-5 cycles and drives strobes and datapath mux selects.
module multicycle_control_unit
  import control_pkg::*;
#(
  parameter int unsigned STATE_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [OPCODE_W-1:0]    opcode_i,
  input  logic [FUNCT3_W-1:0]    funct3_i,
  input  logic                   funct7_b5_i,
  input  logic                   zero_i,
  output logic                   pc_write_o,
  output logic                   adr_src_o,
  output logic                   mem_write_o,
  output logic                   ir_write_o,
  output logic                   reg_write_o,
  output logic [SEL_W-1:0]       result_src_o,
  output logic [SEL_W-1:0]       alu_src_a_o,
  output logic [SEL_W-1:0]       alu_src_b_o,
  output logic [ALUCTRL_W-1:0]   alu_control_o,
  output logic                   illegal_o,
  output logic [STATE_WIDTH-1:0] state_o
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;
  logic   illegal_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state and per-state control word.
  always_comb begin
    state_d   = S_FETCH;
    ctrl      = '0;
    illegal_c = 1'b0;
    case (state_q)
      S_FETCH: begin
        ctrl.ir_write   = 1'b1;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.aluop      = ALUOP_ADD;
        ctrl.result_src = RES_ALURESULT;
        ctrl.pc_update  = 1'b1;
        state_d         = S_DECODE;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.aluop     = ALUOP_ADD;
        case (opcode_i)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTER;
          OP_IALU:      state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BRANCH:    state_d = S_BRANCH;
          default: begin
            state_d   = S_FETCH;
            illegal_c = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_A;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.aluop     = ALUOP_ADD;
        state_d        = opcode_i[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.adr_src    = 1'b1;
        state_d         = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_write  = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEMWRITE: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.adr_src    = 1'b1;
        ctrl.mem_write  = 1'b1;
        state_d         = S_FETCH;
      end
      S_EXECUTER: begin
        ctrl.alu_src_a = SRCA_A;
        ctrl.alu_src_b = SRCB_WD;
        ctrl.aluop     = ALUOP_FUNCT;
        state_d        = S_ALUWB;
      end
      S_EXECUTEI: begin
        ctrl.alu_src_a = SRCA_A;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.aluop     = ALUOP_FUNCT;
        state_d        = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
        state_d         = S_FETCH;
      end
      S_JAL: begin
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.aluop      = ALUOP_ADD;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_update  = 1'b1;
        state_d         = S_ALUWB;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = SRCA_A;
        ctrl.alu_src_b  = SRCB_WD;
        ctrl.aluop      = ALUOP_SUB;
        ctrl.result_src = RES_ALUOUT;
        ctrl.branch     = 1'b1;
        state_d         = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop_i       (ctrl.aluop),
    .funct3_i      (funct3_i),
    .op_b5_i       (opcode_i[5]),
    .funct7_b5_i   (funct7_b5_i),
    .alu_control_o (alu_control_o)
  );

  // Strobes are masked while reset is high so an abandoned instruction never writes.
  assign pc_write_o   = ~reset & (ctrl.pc_update | (ctrl.branch & (zero_i ^ funct3_i[0])));
  assign ir_write_o   = ~reset & ctrl.ir_write;
  assign mem_write_o  = ~reset & ctrl.mem_write;
  assign reg_write_o  = ~reset & ctrl.reg_write;
  assign illegal_o    = ~reset & illegal_c;
  assign adr_src_o    = ctrl.adr_src;
  assign result_src_o = ctrl.result_src;
  assign alu_src_a_o  = ctrl.alu_src_a;
  assign alu_src_b_o  = ctrl.alu_src_b;
  assign state_o      = STATE_WIDTH'(state_q);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed vector table,
// reset corner cases and random instructions against a path-based model.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic       zero;
  logic       pc_write_o, adr_src_o, mem_write_o, ir_write_o, reg_write_o, illegal_o;
  logic [1:0] result_src_o, alu_src_a_o, alu_src_b_o;
  logic [2:0] alu_control_o;
  logic [3:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_control_unit #(.STATE_WIDTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode_i      (opcode),
    .funct3_i      (funct3),
    .funct7_b5_i   (funct7_b5),
    .zero_i        (zero),
    .pc_write_o    (pc_write_o),
    .adr_src_o     (adr_src_o),
    .mem_write_o   (mem_write_o),
    .ir_write_o    (ir_write_o),
    .reg_write_o   (reg_write_o),
    .result_src_o  (result_src_o),
    .alu_src_a_o   (alu_src_a_o),
    .alu_src_b_o   (alu_src_b_o),
    .alu_control_o (alu_control_o),
    .illegal_o     (illegal_o),
    .state_o       (state_o)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [2:0] alu;
    logic       illegal;
    logic [3:0] state;
  } obs_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       zero;
    int         exp_len;
    logic [2:0] exp_alu;
    string      nm;
  } vec_t;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IA = 7'b0010011, JL = 7'b1101111, BR = 7'b1100011;

  function automatic obs_t sample();
    obs_t o;
    o.pc_write = pc_write_o;  o.adr_src = adr_src_o;   o.mem_write = mem_write_o;
    o.ir_write = ir_write_o;  o.reg_write = reg_write_o;
    o.result_src = result_src_o; o.src_a = alu_src_a_o; o.src_b = alu_src_b_o;
    o.alu = alu_control_o;    o.illegal = illegal_o;   o.state = state_o;
    return o;
  endfunction

  // Instruction class: 0 lw, 1 sw, 2 R, 3 I, 4 jal, 5 branch, 6 illegal.
  function automatic int class_of(logic [6:0] op);
    case (op)
      LW: return 0;  SW: return 1;  RT: return 2;
      IA: return 3;  JL: return 4;  BR: return 5;
      default: return 6;
    endcase
  endfunction

  // State visited at cycle idx of an instruction, -1 once it should be over.
  function automatic int path_state(logic [6:0] op, int idx);
    int p[6];
    case (class_of(op))
      0: p = '{0, 1, 2, 3, 4, -1};
      1: p = '{0, 1, 2, 5, -1, -1};
      2: p = '{0, 1, 6, 7, -1, -1};
      3: p = '{0, 1, 8, 7, -1, -1};
      4: p = '{0, 1, 9, 7, -1, -1};
      5: p = '{0, 1, 10, -1, -1, -1};
      default: p = '{0, 1, -1, -1, -1, -1};
    endcase
    return (idx < 6) ? p[idx] : -1;
  endfunction

  function automatic logic [2:0] ref_alu(logic [2:0] f3, logic op5, logic f7);
    if (f3 == 3'b000) return (op5 && f7) ? 3'b001 : 3'b000;
    if (f3 == 3'b010) return 3'b101;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b111) return 3'b010;
    return 3'b000;
  endfunction

  function automatic obs_t model(int st, logic [6:0] op, logic [2:0] f3, logic f7, logic z);
    obs_t e = '0;
    e.state = 4'(st);
    case (st)
      0:  begin e.ir_write = 1; e.pc_write = 1; e.src_b = 2; e.result_src = 2; end
      1:  begin e.src_a = 1; e.src_b = 1; e.illegal = (class_of(op) == 6); end
      2:  begin e.src_a = 2; e.src_b = 1; end
      3:  e.adr_src = 1;
      4:  begin e.result_src = 1; e.reg_write = 1; end
      5:  begin e.adr_src = 1; e.mem_write = 1; end
      6:  begin e.src_a = 2; e.alu = ref_alu(f3, op[5], f7); end
      7:  e.reg_write = 1;
      8:  begin e.src_a = 2; e.src_b = 1; e.alu = ref_alu(f3, op[5], f7); end
      9:  begin e.src_a = 1; e.src_b = 2; e.pc_write = 1; end
      10: begin e.src_a = 2; e.alu = 3'b001; e.pc_write = z ^ f3[0]; end
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic obs_t reset_obs();
    obs_t r = '0;
    r.src_b = 2;
    r.result_src = 2;
    return r;
  endfunction

  task automatic check(input string nm, input obs_t act, input obs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h (state %0d) expected %h (state %0d)",
               nm, act, act.state, exp, exp.state);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Entered with the DUT in FETCH, one time unit after a rising edge.
  task automatic run_instr(input vec_t v);
    int n = 0;
    int st;
    logic [2:0] alu2 = 3'b000;
    opcode = v.op; funct3 = v.f3; funct7_b5 = v.f7; zero = v.zero;
    do begin
      #1;
      st = path_state(v.op, n);
      if (st < 0) st = 0;
      check($sformatf("%s cyc%0d", v.nm, n), sample(), model(st, v.op, v.f3, v.f7, v.zero));
      if (n == 2) alu2 = alu_control_o;
      n++;
      @(posedge clk); #1;
    end while (state_o != 4'd0 && n < 8);
    check_int({v.nm, " latency"}, n, v.exp_len);
    if (v.exp_len > 2) check_int({v.nm, " exec alu"}, int'(alu2), int'(v.exp_alu));
  endtask

  function automatic vec_t mk(logic [6:0] op, logic [2:0] f3, logic f7, logic z,
                              int len, logic [2:0] alu, string nm);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.zero = z;
    v.exp_len = len; v.exp_alu = alu; v.nm = nm;
    return v;
  endfunction

  vec_t vecs[13];

  initial begin
    int lat[7];
    vec_t r;
    lat = '{5, 4, 4, 4, 4, 3, 2};
    vecs[0]  = mk(LW, 3'b010, 0, 0, 5, 3'b000, "lw");
    vecs[1]  = mk(SW, 3'b010, 0, 0, 4, 3'b000, "sw");
    vecs[2]  = mk(RT, 3'b000, 1, 0, 4, 3'b001, "sub");
    vecs[3]  = mk(BR, 3'b000, 0, 1, 3, 3'b001, "beq_taken");
    vecs[4]  = mk(BR, 3'b001, 0, 1, 3, 3'b001, "bne_not_taken");
    vecs[5]  = mk(JL, 3'b000, 0, 0, 4, 3'b000, "jal");
    vecs[6]  = mk(IA, 3'b111, 0, 0, 4, 3'b010, "andi");
    vecs[7]  = mk(7'b0000000, 3'b000, 0, 0, 2, 3'b000, "illegal");
    vecs[8]  = mk(RT, 3'b000, 0, 0, 4, 3'b000, "add");
    vecs[9]  = mk(RT, 3'b010, 0, 0, 4, 3'b101, "slt");
    vecs[10] = mk(RT, 3'b110, 0, 0, 4, 3'b011, "or");
    vecs[11] = mk(IA, 3'b000, 1, 0, 4, 3'b000, "addi_f7set");
    vecs[12] = mk(IA, 3'b100, 0, 0, 4, 3'b000, "xori_other");

    // Reset held with an R-type opcode on the inputs.
    reset = 1'b1; opcode = RT; funct3 = 3'b000; funct7_b5 = 1'b1; zero = 1'b0;
    #2 check("reset initial", sample(), reset_obs());
    repeat (3) begin
      @(posedge clk); #2;
      check("reset held", sample(), reset_obs());
    end
    reset = 1'b0;
    #1 check("first fetch", sample(), model(0, RT, 3'b000, 1'b1, 1'b0));

    foreach (vecs[i]) run_instr(vecs[i]);

    // Reset asserted in MEMREAD abandons the load with no write-back.
    opcode = LW; funct3 = 3'b010; funct7_b5 = 1'b0; zero = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 check($sformatf("lw_abort cyc%0d", c), sample(), model(path_state(LW, c), LW, 3'b010, 0, 0));
      @(posedge clk); #1;
    end
    #1 check("lw_abort memread", sample(), model(3, LW, 3'b010, 0, 0));
    reset = 1'b1;
    #1 check("lw_abort reset now", sample(), reset_obs());
    @(posedge clk); #1;
    check("lw_abort reset edge", sample(), reset_obs());
    reset = 1'b0;
    #1 check("lw_abort refetch", sample(), model(0, LW, 3'b010, 0, 0));
    @(posedge clk); #1;
    check("lw_abort restart decode", sample(), model(1, LW, 3'b010, 0, 0));
    @(posedge clk); #1;
    check("lw_abort restart memadr", sample(), model(2, LW, 3'b010, 0, 0));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;

    // Random instruction stream.
    for (int k = 0; k < 40; k++) begin
      logic [6:0] ops[6];
      int cls;
      ops = '{LW, SW, RT, IA, JL, BR};
      r.op   = ($urandom_range(0, 6) == 6) ? 7'($urandom) : ops[$urandom_range(0, 5)];
      r.f3   = 3'($urandom);
      r.f7   = 1'($urandom);
      r.zero = 1'($urandom);
      cls    = class_of(r.op);
      r.exp_len = lat[cls];
      case (cls)
        2, 3:    r.exp_alu = ref_alu(r.f3, r.op[5], r.f7);
        5:       r.exp_alu = 3'b001;
        default: r.exp_alu = 3'b000;
      endcase
      r.nm = $sformatf("rand%0d_op%b", k, r.op);
      run_instr(r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
